menu_sequencer: RTL and testbench
=================================

MENU_SEQUENCER -- requirements
Module: menu_sequencer

Interface
REQ-001 Parameter AUTO_PERIOD, default 32'd50_000_000: idle cycles before an automatic jump is issued.
REQ-002 Parameter JUMPS_TO_START, default 8: completed jumps that end the menu.
REQ-003 Parameter MOVE_TIMEOUT, default 32'd10_000_000: maximum cycles allowed for one jump handshake.
REQ-004 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port btn_jump, input, 1: one-cycle jump request from the button pulse generator.
REQ-007 Port done_move, input, 1: level from the Q*bert mover; high when at rest, low while moving.
REQ-008 Port jump_pulse, output, 1: one-cycle jump command to the Q*bert mover.
REQ-009 Port color_idx, output, 3: current top-face colour index, 0..NUM_COLORS-1.
REQ-010 Port menu_active, output, 1: high while the menu owns the display.
REQ-011 Port start_game, output, 1: one-cycle pulse when the menu ends.
REQ-012 Port busy, output, 1: high from jump_pulse until the jump completes or times out.
REQ-013 Port timeout_flag, output, 1: sticky; set on any handshake timeout.

Function
REQ-014 The block SHALL implement the states IDLE, FIRE, WAIT_ACK, WAIT_DONE, ADVANCE and FINISHED.
REQ-015 IDLE: a request is btn_jump=1 or a pending flag; on a request, go to FIRE and clear pending.
REQ-016 FIRE: assert jump_pulse for exactly one cycle, clear the handshake counter, go to WAIT_ACK.
REQ-017 WAIT_ACK: on done_move=0, go to WAIT_DONE.
REQ-018 WAIT_DONE: on done_move=1, go to ADVANCE.
REQ-019 busy SHALL be 1 in FIRE, WAIT_ACK and WAIT_DONE, and 0 in every other state.
REQ-020 ADVANCE (one cycle): color_idx increments, wrapping NUM_COLORS-1 to 0; jump_count increments; if the new jump_count equals JUMPS_TO_START, go to FINISHED, otherwise go to IDLE.
REQ-021 btn_jump while busy=1 SHALL set a single pending flag; further presses are dropped, so the queue depth is 1.
REQ-022 btn_jump in ADVANCE SHALL also set the pending flag.
REQ-023 Timeout: in WAIT_ACK or WAIT_DONE, when the handshake counter reaches MOVE_TIMEOUT-1, set timeout_flag and go to ADVANCE (the jump counts as complete).
REQ-024 FINISHED: pulse start_game for one cycle on entry, hold menu_active=0, and ignore all inputs until reset.
REQ-025 The jump-to-jump latency with no timeout SHALL be: request cycle N, jump_pulse at N+1, color_idx updated 1 cycle after done_move returns high.
REQ-026 Counters SHALL be 32-bit unsigned and SHALL saturate rather than wrap.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-handshake.
REQ-028 On reset, color_idx=0, jump_count=0, pending=0, timeout_flag=0, jump_pulse=0, start_game=0, busy=0 and menu_active=1.
REQ-029 btn_jump in the same cycle as reset SHALL be ignored.

Configuration
REQ-030 Macro MENU_AUTOJUMP_EN defined: in IDLE with no request, an idle counter SHALL count up, and on reaching AUTO_PERIOD-1 the block SHALL go to FIRE as if requested.
REQ-031 The idle counter SHALL clear on any request and on leaving IDLE.
REQ-032 Macro MENU_AUTOJUMP_EN undefined: no idle counter SHALL exist and jumps SHALL occur only on btn_jump.

Structure
REQ-033 Package menu_pkg SHALL hold the menu_state_t enum, NUM_COLORS=5 and the colour-index width localparam.
REQ-034 One sub-module, menu_timer, SHALL provide a clearable saturating counter with a terminal-count output, used for both the handshake counter and the idle counter.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Bench parameters: AUTO_PERIOD=20, JUMPS_TO_START=3, MOVE_TIMEOUT=50.
REQ-037 Scenario 1: btn_jump at cycle 5, done_move low at cycles 8-15 -> jump_pulse at cycle 6 only; color_idx 0->1 at cycle 17; busy high for cycles 6-16.
REQ-038 Scenario 2: two btn_jump pulses while busy -> exactly one extra jump_pulse, 1 cycle after the first jump returns to IDLE; final color_idx=2.
REQ-039 Scenario 3: done_move held high after jump_pulse -> timeout_flag=1 at 50 cycles after FIRE; color_idx advances; busy drops.
REQ-040 Scenario 4: three completed jumps -> start_game one-cycle pulse, menu_active=0; a later btn_jump gives no jump_pulse.
REQ-041 Scenario 5: with MENU_AUTOJUMP_EN and no input -> jump_pulse 21 cycles after reset release; without the macro, no jump_pulse in 200 cycles.
REQ-042 Scenario 6: reset asserted in WAIT_DONE with color_idx=2 -> next cycle IDLE, color_idx=0, busy=0, pending=0.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared types and constants for the attract-menu jump sequencer.
package menu_pkg;

    localparam int NUM_COLORS = 5;
    localparam int COLOR_W    = 3;
    localparam int CNT_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIRE      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ADVANCE   = 3'd4,
        ST_FINISHED  = 3'd5
    } menu_state_t;

    function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] c);
        return (c == COLOR_W'(NUM_COLORS - 1)) ? '0 : c + 1'b1;
    endfunction

endpackage

// File: rtl/menu_timer.sv
// Clearable saturating up-counter; tc is high once the count reaches LIMIT-1.
import menu_pkg::*;

module menu_timer #(
    parameter logic [31:0] LIMIT = 32'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // A zero limit behaves like a limit of one rather than underflowing.
    localparam logic [CNT_W-1:0] TC_VAL = (LIMIT == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(LIMIT - 32'd1);

    logic [CNT_W-1:0] count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

    assign tc = (count >= TC_VAL);

endmodule

// File: rtl/menu_sequencer.sv
// Menu jump sequencer: issues jump commands to the mover and cycles the top-face colour.
// Optional MENU_AUTOJUMP_EN adds an idle timer that fires jumps with no button input.
import menu_pkg::*;

module menu_sequencer #(
    parameter logic [31:0] AUTO_PERIOD    = 32'd50_000_000,
    parameter logic [31:0] JUMPS_TO_START = 32'd8,
    parameter logic [31:0] MOVE_TIMEOUT   = 32'd10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_jump,
    input  logic               done_move,
    output logic               jump_pulse,
    output logic [COLOR_W-1:0] color_idx,
    output logic               menu_active,
    output logic               start_game,
    output logic               busy,
    output logic               timeout_flag
);

    menu_state_t      state, state_n;
    logic             pending;
    logic [CNT_W-1:0] jump_count;
    logic             busy_st;
    logic             waiting;
    logic             hs_clr;
    logic             hs_tc;
    logic             auto_req;
    logic             req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign busy_st = (state inside {ST_FIRE, ST_WAIT_ACK, ST_WAIT_DONE});
    assign waiting = (state inside {ST_WAIT_ACK, ST_WAIT_DONE});

    // Handshake timer starts from zero in the FIRE cycle, so the timeout lands MOVE_TIMEOUT cycles after FIRE.
    assign hs_clr = (state_n == ST_FIRE);

    menu_timer #(.LIMIT(MOVE_TIMEOUT)) u_hs_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (hs_clr),
        .en    (busy_st),
        .tc    (hs_tc)
    );

`ifdef MENU_AUTOJUMP_EN
    logic idle_en;
    logic idle_tc;

    assign idle_en = (state == ST_IDLE) && !btn_jump && !pending;

    menu_timer #(.LIMIT(AUTO_PERIOD)) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (!idle_en),
        .en    (idle_en),
        .tc    (idle_tc)
    );

    assign auto_req = (state == ST_IDLE) && idle_tc;
`else
    assign auto_req = 1'b0;
`endif

    assign req = btn_jump || pending || auto_req;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:      if (req) state_n = ST_FIRE;
            ST_FIRE:      state_n = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (hs_tc)           state_n = ST_ADVANCE;
                else if (!done_move) state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (hs_tc || done_move) state_n = ST_ADVANCE;
            ST_ADVANCE:   state_n = (jump_count == JUMPS_TO_START) ? ST_FINISHED : ST_IDLE;
            ST_FINISHED:  state_n = ST_FINISHED;
            default:      state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            color_idx    <= '0;
            jump_count   <= '0;
            timeout_flag <= 1'b0;
            jump_pulse   <= 1'b0;
            start_game   <= 1'b0;
            busy         <= 1'b0;
            menu_active  <= 1'b1;
        end else begin
            state       <= state_n;
            jump_pulse  <= (state_n == ST_FIRE);
            busy        <= (state_n inside {ST_FIRE, ST_WAIT_ACK, ST_WAIT_DONE});
            start_game  <= (state_n == ST_FINISHED) && (state != ST_FINISHED);
            menu_active <= (state_n != ST_FINISHED);

            if ((state == ST_IDLE) && req) begin
                pending <= 1'b0;
            end else if (btn_jump && (busy_st || (state == ST_ADVANCE))) begin
                pending <= 1'b1;
            end

            if (waiting && hs_tc) begin
                timeout_flag <= 1'b1;
            end

            if (state_n == ST_ADVANCE) begin
                color_idx  <= next_color(color_idx);
                jump_count <= sat_inc(jump_count);
            end
        end
    end

endmodule

// File: tb/tb_menu_sequencer.sv
// Directed bench for menu_sequencer; cycle 0 is the first cycle after reset is released.
module tb_menu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_jump = 1'b0;
    logic       done_move = 1'b1;
    logic       jump_pulse;
    logic [2:0] color_idx;
    logic       menu_active;
    logic       start_game;
    logic       busy;
    logic       timeout_flag;

    int checks = 0;
    int failures = 0;

    menu_sequencer #(
        .AUTO_PERIOD    (32'd20),
        .JUMPS_TO_START (32'd3),
        .MOVE_TIMEOUT   (32'd50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_jump     (btn_jump),
        .done_move    (done_move),
        .jump_pulse   (jump_pulse),
        .color_idx    (color_idx),
        .menu_active  (menu_active),
        .start_game   (start_game),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_col(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_jump = 1'b0;
        done_move = 1'b1;
        repeat (3) tick();
        chk_bit("rst_jump_pulse", jump_pulse, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_start_game", start_game, 1'b0);
        chk_bit("rst_timeout", timeout_flag, 1'b0);
        chk_bit("rst_menu_active", menu_active, 1'b1);
        chk_col("rst_color", color_idx, 3'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Scenario 1: single jump with latency check
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            tick();
            btn_jump  = (c == 5);
            done_move = !(c >= 8 && c <= 15);
            chk_bit("s1_jump_pulse", jump_pulse, c == 6);
            chk_bit("s1_busy", busy, (c >= 6 && c <= 16));
            chk_col("s1_color", color_idx, (c >= 17) ? 3'd1 : 3'd0);
        end

        // Scenario 2: two presses while busy queue exactly one extra jump
        do_reset();
        for (int c = 1; c <= 36; c++) begin
            tick();
            btn_jump  = (c == 2 || c == 5 || c == 7);
            done_move = !((c >= 6 && c <= 9) || (c >= 15 && c <= 17));
            chk_bit("s2_jump_pulse", jump_pulse, (c == 3 || c == 13));
            chk_col("s2_color", color_idx, (c >= 19) ? 3'd2 : ((c >= 11) ? 3'd1 : 3'd0));
        end
        chk_bit("s2_menu_active", menu_active, 1'b1);

        // Scenario 3: mover never acknowledges, handshake times out
        do_reset();
        for (int c = 1; c <= 56; c++) begin
            tick();
            btn_jump = (c == 1);
            chk_bit("s3_timeout", timeout_flag, c >= 52);
            chk_bit("s3_busy", busy, (c >= 2 && c <= 51));
            chk_col("s3_color", color_idx, (c >= 52) ? 3'd1 : 3'd0);
        end

        // Scenario 4: third completed jump ends the menu, later input ignored
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick();
            btn_jump  = (c == 1 || c == 11 || c == 21 || c == 32 || c == 35);
            done_move = !((c >= 4 && c <= 5) || (c >= 14 && c <= 15) ||
                          (c >= 24 && c <= 25) || (c >= 33 && c <= 34));
            chk_bit("s4_jump_pulse", jump_pulse, (c == 2 || c == 12 || c == 22));
            chk_bit("s4_start_game", start_game, c == 28);
            chk_bit("s4_menu_active", menu_active, c < 28);
            chk_col("s4_color", color_idx, (c >= 27) ? 3'd3 : ((c >= 17) ? 3'd2 : ((c >= 7) ? 3'd1 : 3'd0)));
        end

        // Scenario 5: automatic jump; cycle -1 is the last cycle with reset high
        do_reset();
`ifdef MENU_AUTOJUMP_EN
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk_bit("s5_auto_jump_pulse", jump_pulse, c == 20);
        end
`else
        begin
            int pulses = 0;
            for (int c = 1; c <= 200; c++) begin
                tick();
                if (jump_pulse === 1'b1) pulses++;
            end
            chk_bit("s5_no_auto_jump", (pulses != 0), 1'b0);
        end
`endif

        // Scenario 6: reset mid-handshake with a pending press and a press during reset
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick();
            btn_jump  = (c == 1 || c == 11 || c == 21 || c == 23 || c == 26 || c == 34);
            done_move = !((c >= 4 && c <= 5) || (c >= 14 && c <= 15) || (c >= 24 && c <= 25));
            reset     = (c == 26);
            if (c >= 24 && c <= 26) begin
                chk_col("s6_color_pre", color_idx, 3'd2);
                chk_bit("s6_busy_pre", busy, 1'b1);
            end
            if (c == 27) begin
                chk_col("s6_color_post", color_idx, 3'd0);
                chk_bit("s6_busy_post", busy, 1'b0);
                chk_bit("s6_menu_active_post", menu_active, 1'b1);
            end
            if (c >= 27) begin
                chk_bit("s6_jump_pulse", jump_pulse, c == 35);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
